// File: rtl/limiter_pwr_seq_if.sv
// CPU register bus of the limiter power sequencer (valid/address/wdata/wstrb/ready).
// The CPU side drives the access strobe and data; the sequencer answers with ready and rdata.
interface limiter_pwr_seq_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [1:0]        address;
    logic [DATA_W-1:0] wdata;
    logic              wstrb;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/limiter_pwr_seq.sv
// Power sequencer for the limiter front-end: timed LDO/bias/isolation ordering driven by the
// limiter's pd bit, with CPU-programmable settle delays and a status register.
module limiter_pwr_seq #(
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int T_LDO_RST  = 16,
    parameter int T_BIAS_RST = 8
) (
    input  logic              clk,
    input  logic              rst,
    limiter_pwr_seq_if.slave  bus,
    input  logic              pd_req,
    output logic              ldo_en,
    output logic              bias_en,
    output logic              iso,
    output logic              pwr_ok
);

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        LDO_UP  = 3'd1,
        BIAS_UP = 3'd2,
        ON      = 3'd3,
        ISO     = 3'd4,
        BIAS_DN = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  t_ldo_q, t_bias_q;
    logic [CNT_W-1:0]  t_ldo_d, t_bias_d;
    logic [DATA_W-1:0] rdata_d;
    logic              busy;
    logic              ldo_d, bias_d, iso_d, ok_d;

    // A delay of 0 behaves like 1: the wait always lasts at least one cycle.
    function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    assign busy = (state_q != OFF) && (state_q != ON);

    // Next-state and counter; loads use the delay registers as they stand before this edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            OFF: begin
                if (!pd_req) begin
                    state_d = LDO_UP;
                    cnt_d   = load_val(t_ldo_q);
                end
            end
            LDO_UP: begin
                if (pd_req) begin
                    state_d = OFF;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = BIAS_UP;
                    cnt_d   = load_val(t_bias_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BIAS_UP: begin
                if (pd_req) begin
                    state_d = BIAS_DN;
                    cnt_d   = load_val(t_bias_q);
                end else if (cnt_q == '0) begin
                    state_d = ON;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ON: begin
                if (pd_req) begin
                    state_d = ISO;
                end
            end
            ISO: begin
                state_d = BIAS_DN;
                cnt_d   = load_val(t_bias_q);
            end
            BIAS_DN: begin
                if (cnt_q == '0) begin
                    state_d = OFF;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so they move on the same edge as the state.
    always_comb begin
        ldo_d  = 1'b0;
        bias_d = 1'b0;
        iso_d  = 1'b1;
        ok_d   = 1'b0;
        unique case (state_d)
            OFF: ;
            LDO_UP: ldo_d = 1'b1;
            BIAS_UP: begin
                ldo_d  = 1'b1;
                bias_d = 1'b1;
            end
            ON: begin
                ldo_d  = 1'b1;
                bias_d = 1'b1;
                iso_d  = 1'b0;
                ok_d   = 1'b1;
            end
            ISO: begin
                ldo_d  = 1'b1;
                bias_d = 1'b1;
            end
            BIAS_DN: ldo_d = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        t_ldo_d  = t_ldo_q;
        t_bias_d = t_bias_q;
        if (bus.valid && bus.wstrb) begin
            unique case (bus.address)
                2'd0: t_ldo_d  = bus.wdata[CNT_W-1:0];
                2'd1: t_bias_d = bus.wdata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = bus.rdata;
        if (bus.valid && !bus.wstrb) begin
            rdata_d = '0;
            unique case (bus.address)
                2'd0: rdata_d = DATA_W'(t_ldo_q);
                2'd1: rdata_d = DATA_W'(t_bias_q);
                2'd2: begin
                    rdata_d[6:4] = state_q;
                    rdata_d[1]   = busy;
                    rdata_d[0]   = pwr_ok;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= OFF;
            cnt_q     <= '0;
            t_ldo_q   <= CNT_W'(T_LDO_RST);
            t_bias_q  <= CNT_W'(T_BIAS_RST);
            bus.ready <= 1'b0;
            bus.rdata <= '0;
            ldo_en    <= 1'b0;
            bias_en   <= 1'b0;
            iso       <= 1'b1;
            pwr_ok    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            t_ldo_q   <= t_ldo_d;
            t_bias_q  <= t_bias_d;
            bus.ready <= bus.valid;
            bus.rdata <= rdata_d;
            ldo_en    <= ldo_d;
            bias_en   <= bias_d;
            iso       <= iso_d;
            pwr_ok    <= ok_d;
        end
    end

endmodule

// File: doc/limiter_pwr_seq.md
Name: limiter_pwr_seq

Overview:
- Power sequencer directly downstream of the limiter control peripheral.
- Consumes the limiter's registered power-down bit (pd) as pd_req.
- Drives the limiter front-end's LDO enable, bias enable and output isolation in a timed order, and reports a power-good flag.
- Exposes a small CPU register interface of the same style (valid/address/wdata/wstrb/ready) for settle-time configuration and status readback.

Parameters:
- DATA_W, 32, CPU data width.
- CNT_W, 16, settle counter and delay register width; CNT_W <= DATA_W.
- T_LDO_RST, 16, reset value of the LDO settle delay register, in clk cycles.
- T_BIAS_RST, 8, reset value of the bias settle delay register, in clk cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- valid  in  1  CPU access strobe
- address  in  2  register select: 0=T_LDO, 1=T_BIAS, 2=STATUS, 3=reserved
- wdata  in  DATA_W  CPU write data
- wstrb  in  1  1=write, 0=read
- rdata  out  DATA_W  CPU read data (registered)
- ready  out  1  access acknowledge
- pd_req  in  1  power-down request from the limiter (pd)
- ldo_en  out  1  limiter LDO enable
- bias_en  out  1  limiter bias enable
- iso  out  1  output isolation, 1=isolated
- pwr_ok  out  1  front-end powered and released

Behaviour:
- One clock, clk. rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values:
  - state=OFF, cnt=0, T_LDO=T_LDO_RST, T_BIAS=T_BIAS_RST
  - ready=0, rdata=0, ldo_en=0, bias_en=0, iso=1, pwr_ok=0
- Reset mid-sequence returns to OFF in the next cycle with all outputs at their reset values.
- CPU interface:
  - ready <= valid every cycle (1-cycle latency); back-to-back accesses allowed.
  - Write (valid&wstrb): address 0 loads T_LDO <= wdata[CNT_W-1:0]; address 1 loads T_BIAS. Writes to 2 and 3 are ignored.
  - Read (valid&~wstrb): rdata registered with ready. Address 0 returns T_LDO and address 1 returns T_BIAS, both zero-extended. Address 2 returns {0.., state[2:0] at bits 6:4, 0 at bits 3:2, busy at bit 1, pwr_ok at bit 0}. Address 3 returns 0.
  - rdata holds its value when valid=0.
  - busy=1 in any state other than OFF and ON.
  - Delay writes during a wait take effect only at the next counter load; they never affect the running count.
- FSM: state codes are OFF=0, LDO_UP=1, BIAS_UP=2, ON=3, ISO=4, BIAS_DN=5. Outputs are registered and decoded from the next state, so they change in the same edge the state changes.
- Outputs by state (ldo_en/bias_en/iso/pwr_ok):
  - OFF 0/0/1/0
  - LDO_UP 1/0/1/0
  - BIAS_UP 1/1/1/0
  - ON 1/1/0/1
  - ISO 1/1/1/0
  - BIAS_DN 1/0/1/0
- Wait length: a wait state lasts exactly max(T,1) cycles. Load cnt = max(T,1)-1 on entry, decrement each cycle, exit when cnt==0.
- Transitions:
  - OFF & pd_req=0 → LDO_UP, load T_LDO.
  - LDO_UP done → BIAS_UP, load T_BIAS.
  - BIAS_UP done → ON.
  - ON & pd_req=1 → ISO, 1 cycle.
  - ISO → BIAS_DN, load T_BIAS.
  - BIAS_DN done → OFF.
- Abort rules:
  - pd_req=1 in LDO_UP → OFF next cycle.
  - pd_req=1 in BIAS_UP → BIAS_DN next cycle, load T_BIAS.
  - pd_req=0 during ISO or BIAS_DN is ignored; power-down completes, then OFF re-evaluates pd_req.
- Latency:
  - Power-up: pwr_ok rises 1+max(T_LDO,1)+max(T_BIAS,1) cycles after the edge where OFF samples pd_req=0.
  - Power-down: pwr_ok and iso change 1 cycle after ON samples pd_req=1; ldo_en falls 1+1+max(T_BIAS,1) cycles after that sample.
- Since the limiter resets with pd=0, the block starts power-up automatically when rst is released.

Test Plan:
- Reset release with pd_req=0, T_LDO=4, T_BIAS=3 → ldo_en=1 at cycle 1, bias_en=1 at cycle 5, iso=0 and pwr_ok=1 at cycle 8; STATUS read returns 0x31.
- From ON, pd_req=1 → iso=1 and pwr_ok=0 at +1, bias_en=0 at +2, ldo_en=0 at +5, STATUS=0x00.
- pd_req pulses high for 1 cycle during LDO_UP → OFF next cycle (ldo_en=0); pd_req back to 0 restarts LDO_UP with a full T_LDO wait.
- pd_req=1 during BIAS_UP → BIAS_DN (bias_en=0, ldo_en=1) for T_BIAS cycles, then OFF; pd_req=0 during BIAS_DN does not shorten the wait.
- Write T_LDO=0 and T_BIAS=0 → power-up takes exactly 3 cycles; write T_LDO=10 during LDO_UP → current wait unchanged, next power-up uses 10; readback of address 0 returns 10, ready=1 one cycle after each valid.
- Assert rst mid-BIAS_UP → next cycle all outputs at reset values, T_LDO and T_BIAS restored to 16 and 8.
